// File: rtl/memory_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Round-robin on ties, registered outputs, timeout with sticky error.
module memory_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifDone,
  output logic [DATA_W-1:0] ifData,
  input  logic              dReq,
  input  logic              dWrite,
  input  logic              dByte,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic              dDone,
  output logic [DATA_W-1:0] dRData,
  output logic              memEn,
  output logic              memWE,
  output logic              memByte,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memReady,
  output logic              busy,
  output logic              memError
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, stateNext;
  logic              lastD, lastDNext;
  logic              ownD, ownDNext;
  logic              ownWr, ownWrNext;
  logic [7:0]        count, countNext;
  logic              pickD;
  logic              ifDoneNext, dDoneNext;
  logic [DATA_W-1:0] ifDataNext, dRDataNext;
  logic              memEnNext, memWENext, memByteNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWDataNext;
  logic              memErrorNext;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= IDLE;
      lastD    <= 1'b0;
      ownD     <= 1'b0;
      ownWr    <= 1'b0;
      count    <= '0;
      ifDone   <= 1'b0;
      dDone    <= 1'b0;
      ifData   <= '0;
      dRData   <= '0;
      memEn    <= 1'b0;
      memWE    <= 1'b0;
      memByte  <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      busy     <= 1'b0;
      memError <= 1'b0;
    end else begin
      state    <= stateNext;
      lastD    <= lastDNext;
      ownD     <= ownDNext;
      ownWr    <= ownWrNext;
      count    <= countNext;
      ifDone   <= ifDoneNext;
      dDone    <= dDoneNext;
      ifData   <= ifDataNext;
      dRData   <= dRDataNext;
      memEn    <= memEnNext;
      memWE    <= memWENext;
      memByte  <= memByteNext;
      memAddr  <= memAddrNext;
      memWData <= memWDataNext;
      busy     <= (stateNext != IDLE);
      memError <= memErrorNext;
    end
  end

  always_comb begin
    stateNext    = state;
    lastDNext    = lastD;
    ownDNext     = ownD;
    ownWrNext    = ownWr;
    countNext    = count;
    pickD        = 1'b0;
    ifDoneNext   = 1'b0;
    dDoneNext    = 1'b0;
    ifDataNext   = ifData;
    dRDataNext   = dRData;
    memEnNext    = memEn;
    memWENext    = memWE;
    memByteNext  = memByte;
    memAddrNext  = memAddr;
    memWDataNext = memWData;
    memErrorNext = memError;
    unique case (state)
      IDLE: begin
        if (ifReq || dReq) begin
          // data wins a tie unless it was the previous owner
          pickD        = dReq && (!ifReq || !lastD);
          lastDNext    = pickD;
          ownDNext     = pickD;
          ownWrNext    = pickD && dWrite;
          countNext    = '0;
          memEnNext    = 1'b1;
          memWENext    = pickD && dWrite;
          memByteNext  = pickD && dByte;
          memAddrNext  = pickD ? dAddr : ifAddr;
          memWDataNext = pickD ? dWData : '0;
          stateNext    = ACCESS;
        end
      end
      ACCESS: begin
        if (memReady || count == 8'(TIMEOUT - 1)) begin
          memEnNext   = 1'b0;
          memWENext   = 1'b0;
          memByteNext = 1'b0;
          stateNext   = DONE;
          ifDoneNext  = !ownD;
          dDoneNext   = ownD;
          if (!memReady) begin
            memErrorNext = 1'b1;
          end
          if (!ownD) begin
            ifDataNext = memReady ? memRData : '1;
          end else if (!ownWr) begin
            dRDataNext = memReady ? memRData : '1;
          end
        end else begin
          countNext = count + 8'd1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized bench for memory_port_arbiter against a
// transaction-level model of grant order, latency and data.
module tb_memory_port_arbiter;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        resetN;
  logic        ifReq;
  logic [15:0] ifAddr;
  logic        ifDone;
  logic [15:0] ifData;
  logic        dReq;
  logic        dWrite;
  logic        dByte;
  logic [15:0] dAddr;
  logic [15:0] dWData;
  logic        dDone;
  logic [15:0] dRData;
  logic        memEn;
  logic        memWE;
  logic        memByte;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  logic        memReady;
  logic        busy;
  logic        memError;

  int passCnt = 0;
  int totalCnt = 0;

  logic [15:0] expIf = '0;
  logic [15:0] expD = '0;
  logic        expErr = 1'b0;
  bit          expLastD = 1'b0;

  memory_port_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .ifReq(ifReq),
    .ifAddr(ifAddr),
    .ifDone(ifDone),
    .ifData(ifData),
    .dReq(dReq),
    .dWrite(dWrite),
    .dByte(dByte),
    .dAddr(dAddr),
    .dWData(dWData),
    .dDone(dDone),
    .dRData(dRData),
    .memEn(memEn),
    .memWE(memWE),
    .memByte(memByte),
    .memAddr(memAddr),
    .memWData(memWData),
    .memRData(memRData),
    .memReady(memReady),
    .busy(busy),
    .memError(memError)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    ifReq = 1'b0;
    dReq = 1'b0;
    memReady = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    expIf = '0;
    expD = '0;
    expErr = 1'b0;
    expLastD = 1'b0;
  endtask

  // One isolated access; memReady arrives after `delay` stalled cycles.
  task automatic do_access(input bit isD, input bit wr, input bit by,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input logic [15:0] rd, input int delay,
                           input string tag);
    int cyc;
    int expCyc;
    bit tmo;
    ifReq = !isD;
    dReq = isD;
    dWrite = wr;
    dByte = by;
    ifAddr = addr;
    dAddr = addr;
    dWData = wd;
    memReady = 1'b0;
    memRData = rd;
    tick();
    ifReq = 1'b0;
    dReq = 1'b0;
    ifAddr = ~addr;
    dAddr = ~addr;
    dWData = ~wd;
    dWrite = ~wr;
    dByte = ~by;
    expLastD = isD;
    tmo = (delay >= TO);
    expCyc = tmo ? TO : delay + 1;
    cyc = 0;
    while (memEn === 1'b1 && cyc < 40) begin
      totalCnt++;
      if (memAddr !== addr || memWE !== (isD & wr) ||
          memByte !== (isD & by) ||
          (isD && wr && memWData !== wd))
        $display("FAIL %s_bus cyc=%0d got a=%h we=%b by=%b wd=%h want a=%h we=%b by=%b wd=%h",
                 tag, cyc, memAddr, memWE, memByte, memWData,
                 addr, isD & wr, isD & by, wd);
      else passCnt++;
      memReady = (cyc == delay);
      cyc++;
      tick();
    end
    memReady = 1'b0;
    if (tmo) begin
      expErr = 1'b1;
      if (!isD) expIf = '1;
      else if (!wr) expD = '1;
    end else begin
      if (!isD) expIf = rd;
      else if (!wr) expD = rd;
    end
    totalCnt++;
    if (cyc !== expCyc)
      $display("FAIL %s_len got %0d want %0d", tag, cyc, expCyc);
    else passCnt++;
    totalCnt++;
    if ({ifDone, dDone, busy} !== {!isD, isD, 1'b1})
      $display("FAIL %s_done got if=%b d=%b busy=%b want if=%b d=%b busy=1",
               tag, ifDone, dDone, busy, !isD, isD);
    else passCnt++;
    totalCnt++;
    if (ifData !== expIf || dRData !== expD || memError !== expErr)
      $display("FAIL %s_data got if=%h d=%h err=%b want if=%h d=%h err=%b",
               tag, ifData, dRData, memError, expIf, expD, expErr);
    else passCnt++;
    tick();
    totalCnt++;
    if ({ifDone, dDone, busy, memEn} !== 4'b0)
      $display("FAIL %s_idle got if=%b d=%b busy=%b en=%b want 0",
               tag, ifDone, dDone, busy, memEn);
    else passCnt++;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    ifReq = 1'b1;
    ifAddr = 16'h1234;
    memReady = 1'b1;
    memRData = 16'h5a5a;
    tick();
    tick();
    totalCnt++;
    if ({ifDone, dDone, memEn, memWE, memByte, busy, memError} !== 7'b0 ||
        ifData !== 16'h0 || dRData !== 16'h0 ||
        memAddr !== 16'h0 || memWData !== 16'h0)
      $display("FAIL reset_outs got en=%b busy=%b err=%b ifd=%h dd=%h a=%h want 0",
               memEn, busy, memError, ifData, dRData, memAddr);
    else passCnt++;
    resetN = 1'b1;
    #3;
    totalCnt++;
    if (memEn !== 1'b0)
      $display("FAIL reset_rise got en=%b want 0", memEn);
    else passCnt++;
    tick();
    ifReq = 1'b0;
    totalCnt++;
    if (memEn !== 1'b1 || memAddr !== 16'h1234)
      $display("FAIL reset_grant got en=%b a=%h want en=1 a=1234", memEn, memAddr);
    else passCnt++;
    tick();
    totalCnt++;
    if (ifDone !== 1'b1 || ifData !== 16'h5a5a)
      $display("FAIL reset_fetch got done=%b d=%h want 1 5a5a", ifDone, ifData);
    else passCnt++;
    tick();
    memReady = 1'b0;
    expIf = 16'h5a5a;
    expD = '0;
    expErr = 1'b0;
    expLastD = 1'b0;
  endtask

  task automatic test_fetch();
    do_access(1'b0, 1'b1, 1'b1, 16'h0040, 16'h7777, 16'ha5c3, 0, "fetch");
  endtask

  task automatic test_tie();
    logic [15:0] rd;
    bit winD;
    int w;
    do_reset();
    ifAddr = 16'h1111;
    dAddr = 16'h2222;
    dWrite = 1'b0;
    dByte = 1'b0;
    memReady = 1'b1;
    ifReq = 1'b1;
    dReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (memEn !== 1'b1 && w < 5) begin
        tick();
        w++;
      end
      winD = !expLastD;
      expLastD = winD;
      totalCnt++;
      if (memEn !== 1'b1 || memAddr !== (winD ? 16'h2222 : 16'h1111))
        $display("FAIL tie_grant%0d got en=%b a=%h want en=1 a=%h",
                 i, memEn, memAddr, winD ? 16'h2222 : 16'h1111);
      else passCnt++;
      rd = 16'($urandom);
      memRData = rd;
      tick();
      if (winD) expD = rd;
      else expIf = rd;
      totalCnt++;
      if ({ifDone, dDone} !== {!winD, winD} ||
          ifData !== expIf || dRData !== expD)
        $display("FAIL tie_done%0d got if=%b d=%b ifd=%h dd=%h want if=%b d=%b ifd=%h dd=%h",
                 i, ifDone, dDone, ifData, dRData, !winD, winD, expIf, expD);
      else passCnt++;
      tick();
      if (i == 3) begin
        ifReq = 1'b0;
        dReq = 1'b0;
      end
      totalCnt++;
      if (memEn !== 1'b0 || busy !== 1'b0 || ifDone !== 1'b0 || dDone !== 1'b0)
        $display("FAIL tie_gap%0d got en=%b busy=%b want 0", i, memEn, busy);
      else passCnt++;
    end
    memReady = 1'b0;
    tick();
  endtask

  task automatic test_byte_store();
    do_access(1'b1, 1'b1, 1'b1, 16'h0101, 16'h00ff, 16'hbeef, 3, "bstore");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_access(1'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 5)), $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0, 16'h1357, TO - 1, "edge14");
    do_access(1'b1, 1'b0, 1'b0, 16'h0302, 16'h0, 16'h2468, 1000, "tmo");
    do_access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h9abc, 1, "sticky");
  endtask

  task automatic test_mid_reset();
    dReq = 1'b1;
    dWrite = 1'b0;
    dByte = 1'b0;
    dAddr = 16'h0500;
    memReady = 1'b0;
    tick();
    dReq = 1'b0;
    tick();
    totalCnt++;
    if (memEn !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid_access got en=%b busy=%b want 1 1", memEn, busy);
    else passCnt++;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    memReady = 1'b1;
    totalCnt++;
    if ({memEn, busy, dDone, ifDone, memError} !== 5'b0 || ifData !== 16'h0)
      $display("FAIL mid_reset got en=%b busy=%b dd=%b err=%b ifd=%h want 0",
               memEn, busy, dDone, memError, ifData);
    else passCnt++;
    tick();
    tick();
    totalCnt++;
    if ({memEn, busy, dDone, ifDone} !== 4'b0)
      $display("FAIL mid_after got en=%b busy=%b dd=%b want 0", memEn, busy, dDone);
    else passCnt++;
    memReady = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    ifReq = 1'b0;
    ifAddr = '0;
    dReq = 1'b0;
    dWrite = 1'b0;
    dByte = 1'b0;
    dAddr = '0;
    dWData = '0;
    memRData = '0;
    memReady = 1'b0;
    #2;
    test_reset();
    test_fetch();
    test_tie();
    test_byte_store();
    test_random();
    test_timeout();
    test_mid_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
